// File: rtl/issue_if.sv
// Issue-stage bundle between the issue queues and the scheduler.
// Handshake: ready_* says a queue head may issue. issue_* is a same-cycle pop, and a pop happens only when both are high.
interface issue_if #(
    parameter int DIV_LAT = 7
);
    logic               ready_int;
    logic               ready_mult;
    logic               ready_div;
    logic               ready_ld_st;
    logic               flush;
    logic               issue_int;
    logic               issue_mult;
    logic               issue_div;
    logic               issue_ld_st;
    logic               div_busy;
    logic [DIV_LAT-1:0] cdb_rsv;

    modport master (
        output ready_int, ready_mult, ready_div, ready_ld_st, flush,
        input  issue_int, issue_mult, issue_div, issue_ld_st, div_busy, cdb_rsv
    );

    modport slave (
        input  ready_int, ready_mult, ready_div, ready_ld_st, flush,
        output issue_int, issue_mult, issue_div, issue_ld_st, div_busy, cdb_rsv
    );
endinterface

// File: rtl/issue_scheduler.sv
// Issue-stage controller: grants queue heads so that fixed-latency results never share a CDB cycle.
// It tracks the non-pipelined divider and round-robins between int and ld_st.
module issue_scheduler #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7
) (
    input  logic    clk,
    input  logic    rst_n,
    issue_if.slave  iq
);
    localparam int CNT_W = $clog2(DIV_LAT + 1);

    // rsv[k] set means the CDB is already claimed k cycles from now.
    logic [DIV_LAT:1]  rsv, rsv_n;
    logic [CNT_W-1:0]  div_cnt, div_cnt_n;
    logic              rr_ptr, rr_ptr_n;
    logic              div_busy;
    logic              gnt_int, gnt_mult, gnt_div, gnt_ld_st;

    assign div_busy = (div_cnt != '0);

    // Grants are Mealy. They are forced low while in reset so that queues are never popped then.
    always_comb begin
        gnt_int   = 1'b0;
        gnt_mult  = 1'b0;
        gnt_div   = 1'b0;
        gnt_ld_st = 1'b0;
        if (rst_n && !iq.flush) begin
            gnt_div  = iq.ready_div && !div_busy && !rsv[DIV_LAT];
            gnt_mult = iq.ready_mult && !rsv[MULT_LAT];
            if (!rsv[1]) begin
                if (iq.ready_int && iq.ready_ld_st) begin
                    gnt_int   = !rr_ptr;
                    gnt_ld_st = rr_ptr;
                end else begin
                    gnt_int   = iq.ready_int;
                    gnt_ld_st = iq.ready_ld_st;
                end
            end
        end
    end

    // An int/ld_st result lands next cycle, so it never needs a future reservation bit.
    always_comb begin
        rsv_n = '0;
        for (int k = 1; k < DIV_LAT; k++) begin
            rsv_n[k] = rsv[k+1];
        end
        rsv_n[MULT_LAT-1] = rsv_n[MULT_LAT-1] | gnt_mult;
        rsv_n[DIV_LAT-1]  = rsv_n[DIV_LAT-1] | gnt_div;

        div_cnt_n = div_cnt;
        if (gnt_div) begin
            div_cnt_n = CNT_W'(DIV_LAT - 1);
        end else if (div_busy) begin
            div_cnt_n = div_cnt - 1'b1;
        end

        rr_ptr_n = rr_ptr;
        if (gnt_int) begin
            rr_ptr_n = 1'b1;
        end else if (gnt_ld_st) begin
            rr_ptr_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsv     <= '0;
            div_cnt <= '0;
            rr_ptr  <= 1'b0;
        end else begin
            rsv     <= rsv_n;
            div_cnt <= div_cnt_n;
            rr_ptr  <= rr_ptr_n;
        end
    end

    assign iq.issue_int   = gnt_int;
    assign iq.issue_mult  = gnt_mult;
    assign iq.issue_div   = gnt_div;
    assign iq.issue_ld_st = gnt_ld_st;
    assign iq.div_busy    = div_busy;
    assign iq.cdb_rsv     = rsv;

    a_mult_slot_free: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_mult |-> !rsv[MULT_LAT]);
    a_div_slot_free: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_div |-> (!rsv[DIV_LAT] && !div_busy));
    a_short_single: assert property (@(posedge clk) disable iff (!rst_n)
        !(gnt_int && gnt_ld_st));
    a_short_slot_free: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt_int || gnt_ld_st) |-> !rsv[1]);
    a_top_clear: assert property (@(posedge clk) disable iff (!rst_n)
        !rsv[DIV_LAT]);
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler with MULT_LAT=4 and DIV_LAT=7.
// Expected grants, busy flags and reservation vectors are hand-computed per cycle.
module tb_issue_scheduler;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    issue_if #(.DIV_LAT(DIV_LAT)) iq ();

    issue_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iq    (iq)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          collisions = 0;
    int          cdb_use[int];
    logic [3:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // in_v = {ready_int, ready_mult, ready_div, ready_ld_st, flush}
    task automatic drive(input logic [4:0] in_v);
        {iq.ready_int, iq.ready_mult, iq.ready_div, iq.ready_ld_st, iq.flush} = in_v;
    endtask

    function automatic logic [3:0] grants();
        return {iq.issue_int, iq.issue_mult, iq.issue_div, iq.issue_ld_st};
    endfunction

    // Each granted op books the cycle it will drive the CDB. A booking into a cycle that is already taken is a collision.
    task automatic book(input int slot);
        if (cdb_use.exists(slot)) collisions++;
        cdb_use[slot] = 1;
    endtask

    // exp_g = {issue_int, issue_mult, issue_div, issue_ld_st}
    task automatic step(input string tag, input logic [4:0] in_v, input logic [3:0] exp_g,
                        input logic exp_busy, input logic [6:0] exp_rsv);
        logic [3:0] got;
        drive(in_v);
        exp_q.push_back(exp_g);
        #2;
        got = grants();
        check({tag, ".grant"}, 32'(got), 32'(exp_q.pop_front()));
        check({tag, ".busy"}, 32'(iq.div_busy), 32'(exp_busy));
        check({tag, ".rsv"}, 32'(iq.cdb_rsv), 32'(exp_rsv));
        if (got[3]) book(cyc + 1);
        if (got[0]) book(cyc + 1);
        if (got[2]) book(cyc + MULT_LAT);
        if (got[1]) book(cyc + DIV_LAT);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        drive(5'b11110);
        #2;
        check({tag, ".grant"}, 32'(grants()), 32'h0);
        check({tag, ".busy"}, 32'(iq.div_busy), 32'h0);
        check({tag, ".rsv"}, 32'(iq.cdb_rsv), 32'h0);
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        drive(5'b00000);
        cdb_use.delete();
    endtask

    initial begin
        drive(5'b00000);

        // Int only: granted every cycle, no reservations.
        apply_reset("rst0");
        for (int i = 0; i < 4; i++) step("s1_int", 5'b10000, 4'b1000, 1'b0, 7'h00);

        // Int and ld_st contend: round-robin starting with int.
        apply_reset("rst1");
        step("s2_rr0", 5'b10010, 4'b1000, 1'b0, 7'h00);
        step("s2_rr1", 5'b10010, 4'b0001, 1'b0, 7'h00);
        step("s2_rr2", 5'b10010, 4'b1000, 1'b0, 7'h00);
        step("s2_rr3", 5'b10010, 4'b0001, 1'b0, 7'h00);
        step("s2_ld_only", 5'b00010, 4'b0001, 1'b0, 7'h00);
        step("s2_rr4", 5'b10010, 4'b1000, 1'b0, 7'h00);

        // A mult at t=0 owns the CDB at t=4, which blocks the int issue at t=3.
        apply_reset("rst2");
        step("s3_t0", 5'b11000, 4'b1100, 1'b0, 7'h00);
        step("s3_t1", 5'b10000, 4'b1000, 1'b0, 7'h04);
        step("s3_t2", 5'b10000, 4'b1000, 1'b0, 7'h02);
        step("s3_t3", 5'b10000, 4'b0000, 1'b0, 7'h01);
        step("s3_t4", 5'b10000, 4'b1000, 1'b0, 7'h00);

        // Back-to-back divides are DIV_LAT cycles apart.
        apply_reset("rst3");
        step("s4_t0", 5'b00100, 4'b0010, 1'b0, 7'h00);
        step("s4_t1", 5'b00100, 4'b0000, 1'b1, 7'h20);
        step("s4_t2", 5'b00100, 4'b0000, 1'b1, 7'h10);
        step("s4_t3", 5'b00100, 4'b0000, 1'b1, 7'h08);
        step("s4_t4", 5'b00100, 4'b0000, 1'b1, 7'h04);
        step("s4_t5", 5'b00100, 4'b0000, 1'b1, 7'h02);
        step("s4_t6", 5'b00100, 4'b0000, 1'b1, 7'h01);
        step("s4_t7", 5'b00100, 4'b0010, 1'b0, 7'h00);
        step("s4_t8", 5'b00100, 4'b0000, 1'b1, 7'h20);

        // A div at t=0 owns slot 7, so a mult at t=3 waits until t=4.
        apply_reset("rst4");
        step("s5_t0", 5'b00100, 4'b0010, 1'b0, 7'h00);
        step("s5_t1", 5'b00000, 4'b0000, 1'b1, 7'h20);
        step("s5_t2", 5'b00000, 4'b0000, 1'b1, 7'h10);
        step("s5_t3", 5'b01000, 4'b0000, 1'b1, 7'h08);
        step("s5_t4", 5'b01000, 4'b0100, 1'b1, 7'h04);
        step("s5_t5", 5'b00000, 4'b0000, 1'b1, 7'h06);
        step("s5_t6", 5'b00000, 4'b0000, 1'b1, 7'h03);
        step("s5_t7", 5'b00000, 4'b0000, 1'b0, 7'h01);
        step("s5_t8", 5'b00000, 4'b0000, 1'b0, 7'h00);

        // Flush blocks grants while reservations keep shifting. Then reset is asserted mid-divide.
        apply_reset("rst5");
        step("s6_t0", 5'b11110, 4'b1110, 1'b0, 7'h00);
        step("s6_flush", 5'b11111, 4'b0000, 1'b1, 7'h24);
        step("s6_t2", 5'b11110, 4'b0101, 1'b1, 7'h12);
        drive(5'b00100);
        #1;
        check("s6_pre.busy", 32'(iq.div_busy), 32'h1);
        check("s6_pre.rsv", 32'(iq.cdb_rsv), 32'h0d);
        check("s6_pre.grant", 32'(grants()), 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("s6_async.busy", 32'(iq.div_busy), 32'h0);
        check("s6_async.rsv", 32'(iq.cdb_rsv), 32'h0);
        check("s6_async.grant", 32'(grants()), 32'h0);
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        cdb_use.delete();
        step("s6_after", 5'b00100, 4'b0010, 1'b0, 7'h00);

        check("cdb_collisions", 32'(collisions), 32'h0);
        check("exp_q_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Issue-stage controller for the out-of-order RISC-V core.
- Sits between the four issue queues (int, mult, div, ld_st) and their execution units. Each cycle it decides which queue heads may issue.
- Every functional unit (FU) has a fixed latency, and all results share a single common data bus (CDB). The block holds a CDB slot-reservation shift register so that no two results land on the CDB in the same cycle.
- It also tracks the non-pipelined divider and round-robins int vs ld_st, which contend for the same CDB slot.

Parameters:
- MULT_LAT, 4, multiplier latency in cycles from issue to CDB write (pipelined unit).
- DIV_LAT, 7, divider latency in cycles (non-pipelined). Legal range: 2 <= MULT_LAT < DIV_LAT <= 15.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ready_int  in  1  int queue head has both operands valid.
- ready_mult  in  1  mult queue head ready.
- ready_div  in  1  div queue head ready.
- ready_ld_st  in  1  ld_st queue head ready (address operands valid).
- flush  in  1  mispredict flush; suppresses all grants this cycle.
- issue_int  out  1  grant/pop int queue this cycle.
- issue_mult  out  1  grant mult.
- issue_div  out  1  grant div.
- issue_ld_st  out  1  grant ld_st.
- div_busy  out  1  divider occupied.
- cdb_rsv  out  DIV_LAT  reservation vector; bit k-1 set means the CDB is claimed k cycles ahead.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset clears rsv[DIV_LAT:1], div_cnt and rr_ptr (0 = int preferred next). All issue_* outputs are 0 while rst_n is low. div_busy = 0 and cdb_rsv = 0.
- Grants are combinational (Mealy) from the inputs and registered state, zero-cycle latency.
- Fixed latencies:
  - int = 1, ld_st = 1, mult = MULT_LAT, div = DIV_LAT.
  - An op issued in cycle t drives the CDB in cycle t+L.
- Slot rule: a grant with latency L is legal only if rsv[L] == 0.
- Grant conditions (each is additionally masked by !flush):
  - issue_div = ready_div & !div_busy & !rsv[DIV_LAT].
  - issue_mult = ready_mult & !rsv[MULT_LAT].
  - int/ld_st, only when rsv[1] == 0:
    - If exactly one is ready, grant it.
    - If both are ready, grant int when rr_ptr == 0, else ld_st.
- Up to three grants per cycle: div, mult, and one of int/ld_st. Their latencies differ, so these grants never collide.
- Reservation update each cycle:
  - rsv_n[k] = rsv[k+1] | (grant with L == k+1), for k = 1..DIV_LAT-1.
  - rsv_n[DIV_LAT] = 0.
  - The int/ld_st grant (L = 1) sets no future bit, since its slot is the next cycle. rsv[1] is still consulted because a mult or div result may occupy it.
- rr_ptr: on issue_int it becomes 1; on issue_ld_st it becomes 0; otherwise it holds.
- Divider:
  - issue_div loads div_cnt = DIV_LAT - 1.
  - While div_cnt != 0 it decrements and div_busy = 1.
  - A new div may issue in the cycle div_cnt reaches 0, giving back-to-back divides DIV_LAT cycles apart.
- Flush: blocks grants only. Existing reservations, div_cnt and rr_ptr continue to evolve, because in-flight ops still complete and write the CDB.
- Reset mid-operation: all state clears immediately. Downstream FUs are reset by the same rst_n.
- No X propagation: with all ready inputs at 0, all outputs are 0 and the state only shifts/decays.

Test Plan:
- Reset, then ready_int = 1 alone every cycle -> issue_int = 1 every cycle, cdb_rsv stays 0.
- ready_int = ready_ld_st = 1 held for 4 cycles -> grants alternate int, ld_st, int, ld_st.
- ready_mult pulse at t=0 with MULT_LAT=4, then ready_int held -> issue_mult at t=0; issue_int at t=0..2 and at t=4, but suppressed at t=3 (slot t+4 owned by mult).
- ready_div held with DIV_LAT=7 -> issue_div at t=0 and t=7 only; div_busy = 1 for t=1..6.
- Conflict: div issued at t=0, ready_mult asserted at t=3 (MULT_LAT=4, target slot 7) -> mult suppressed at t=3, granted at t=4; no two reservations ever share a slot (assertion over the whole run).
- flush = 1 with all ready_* = 1 -> all issue_* = 0 that cycle. Prior reservations keep shifting, and rst_n low mid-divide clears div_busy and cdb_rsv asynchronously.
